lsu_bus_if: RTL and testbench

Load/store unit bus interface sitting directly downstream of the core's memory-access signals (alu_result address, rs2 store data, mem_write / mem_to_reg / mem_op). It turns each single-cycle load or store request into a valid/ready bus transaction with byte strobes, and holds the core with `stall` until the access completes. Load data is lane-aligned and sign/zero-extended before it is returned to the write-back mux. It replaces the zero-latency data_mem path when data memory sits behind a multi-cycle bus.

---
 rtl/lsu_bus_if.sv | 221 ++++++++++++++++++++++
 tb/tb_lsu_bus_if.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_if.sv
// Load/store unit bus interface.
// Each single-cycle load or store request from the core becomes one
// valid/ready bus transaction with byte strobes. The core is held with
// `stall` until the access completes. Load data is taken from the addressed
// lane and sign- or zero-extended before it goes to the write-back mux.
module lsu_bus_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_rd_en,
    input  logic                  req_wr_en,
    input  logic [2:0]            req_mem_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [3:0]            bus_wstrb,
    input  logic                  bus_rvalid,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // Counter value on the last cycle allowed in REQ+WAIT.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            op_q;
    logic                  we_q;
    logic [3:0]            wstrb_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [7:0]            cnt;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  req_any;
    logic                  req_bad;
    logic [3:0]            new_wstrb;
    logic [DATA_WIDTH-1:0] new_wdata;
    logic [7:0]            lane_byte;
    logic [15:0]           lane_half;
    logic [DATA_WIDTH-1:0] load_ext;
    logic                  timed_out;
    logic                  done_err;
    logic                  capture_load;
    logic                  clear_rdata;

    assign req_any   = req_rd_en | req_wr_en;
    assign timed_out = (cnt >= TIMEOUT_LAST);

    assign stall     = ((state == IDLE) && req_any) || (state == REQ) || (state == WAIT);
    assign bus_valid = (state == REQ);
    assign bus_we    = we_q;
    assign bus_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign bus_wdata = wdata_q;
    assign bus_wstrb = wstrb_q;
    assign rdata     = rdata_q;
    assign err       = err_q;

    // Classify the incoming request: both enables, unsupported op, or misaligned address.
    always_comb begin
        req_bad = 1'b0;
        if (req_rd_en && req_wr_en) begin
            req_bad = 1'b1;
        end else if (req_wr_en) begin
            if (!(req_mem_op inside {3'b000, 3'b001, 3'b010})) begin
                req_bad = 1'b1;
            end
        end else if (req_rd_en) begin
            if (req_mem_op inside {3'b011, 3'b110, 3'b111}) begin
                req_bad = 1'b1;
            end
        end
        case (req_mem_op[1:0])
            2'b01:   if (req_addr[0] != 1'b0) req_bad = 1'b1;
            2'b10:   if (req_addr[1:0] != 2'b00) req_bad = 1'b1;
            default: ;
        endcase
    end

    // Build the byte strobes and lane-replicated store data from size and address.
    always_comb begin
        new_wstrb = 4'b0000;
        new_wdata = req_wdata;
        case (req_mem_op[1:0])
            2'b00: begin
                new_wdata = {4{req_wdata[7:0]}};
                if (req_wr_en) new_wstrb = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                new_wdata = {2{req_wdata[15:0]}};
                if (req_wr_en) new_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                if (req_wr_en) new_wstrb = 4'b1111;
            end
            default: ;
        endcase
    end

    // Pick the addressed byte/half from the response word and extend it.
    always_comb begin
        lane_byte = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (op_q)
            3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_ext = {24'd0, lane_byte};
            3'b101:  load_ext = {16'd0, lane_half};
            default: load_ext = bus_rdata;
        endcase
    end

    // Next-state logic; completion in a cycle wins over a timeout in that cycle.
    always_comb begin
        state_next   = state;
        done_err     = 1'b0;
        capture_load = 1'b0;
        clear_rdata  = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    if (req_bad) begin
                        state_next  = DONE;
                        done_err    = 1'b1;
                        clear_rdata = 1'b1;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (bus_ready) begin
                    state_next = we_q ? DONE : WAIT;
                end else if (timed_out) begin
                    state_next  = DONE;
                    done_err    = 1'b1;
                    clear_rdata = 1'b1;
                end
            end
            WAIT: begin
                if (bus_rvalid) begin
                    state_next   = DONE;
                    capture_load = 1'b1;
                end else if (timed_out) begin
                    state_next  = DONE;
                    done_err    = 1'b1;
                    clear_rdata = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the request fields when a legal access is accepted, so they stay put while bus_valid is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            op_q    <= 3'b000;
            we_q    <= 1'b0;
            wstrb_q <= 4'b0000;
            wdata_q <= '0;
        end else if ((state == IDLE) && (state_next == REQ)) begin
            addr_q  <= req_addr;
            op_q    <= req_mem_op;
            we_q    <= req_wr_en;
            wstrb_q <= new_wstrb;
            wdata_q <= new_wdata;
        end
    end

    // Timeout counter: cleared when a transaction starts, counts every cycle spent in REQ or WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if ((state == IDLE) && (state_next == REQ)) begin
            cnt <= 8'd0;
        end else if ((state == REQ) || (state == WAIT)) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Result registers: rdata only changes on entry to DONE, err is high for the DONE cycle only.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= done_err;
            if (capture_load) begin
                rdata_q <= load_ext;
            end else if (clear_rdata) begin
                rdata_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_bus_if.sv
// Directed testbench for lsu_bus_if with a small bus responder model.
module tb_lsu_bus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_rd_en;
    logic        req_wr_en;
    logic [2:0]  req_mem_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        err;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int          checks = 0;
    int          failures = 0;

    int          ready_delay = 0;
    bit          rvalid_en = 1'b0;
    logic [31:0] resp_word = 32'd0;
    int          vcnt = 0;
    logic        rv_pending = 1'b0;
    int          hs_count = 0;

    int          stall_n;
    int          valid_n;
    int          hs_before;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [31:0] cap_wstrb;
    logic [31:0] cap_we;

    lsu_bus_if #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_rd_en(req_rd_en),
        .req_wr_en(req_wr_en),
        .req_mem_op(req_mem_op),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .stall(stall),
        .rdata(rdata),
        .err(err),
        .bus_valid(bus_valid),
        .bus_ready(bus_ready),
        .bus_we(bus_we),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb),
        .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Bus responder: ready after ready_delay waiting cycles, read data one cycle after accept.
    always @(posedge clk) begin
        if (bus_valid && !bus_ready) vcnt <= vcnt + 1;
        else vcnt <= 0;
        rv_pending <= rvalid_en && bus_valid && bus_ready && !bus_we;
        if (bus_valid && bus_ready) hs_count <= hs_count + 1;
    end

    assign bus_ready  = bus_valid && (vcnt >= ready_delay);
    assign bus_rvalid = rv_pending;
    assign bus_rdata  = resp_word;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] op,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        req_rd_en  = rd;
        req_wr_en  = wr;
        req_mem_op = op;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    // Present a request and hold it until stall drops (the DONE cycle), bounded to 40 cycles.
    task automatic runAccess(input logic rd, input logic wr, input logic [2:0] op,
                             input logic [31:0] addr, input logic [31:0] wdata);
        nextCycle();
        applyStimulus(rd, wr, op, addr, wdata);
        stall_n   = 0;
        valid_n   = 0;
        cap_addr  = 32'hFFFF_FFFF;
        cap_wdata = 32'hFFFF_FFFF;
        cap_wstrb = 32'hFFFF_FFFF;
        cap_we    = 32'hFFFF_FFFF;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall) break;
            stall_n++;
            if (bus_valid) begin
                valid_n++;
                cap_addr  = bus_addr;
                cap_wdata = bus_wdata;
                cap_wstrb = {28'd0, bus_wstrb};
                cap_we    = {31'd0, bus_we};
            end
            nextCycle();
        end
    endtask

    task automatic checkDone(input string tag, input int exp_stall, input int exp_valid,
                             input logic exp_err, input logic [31:0] exp_rdata);
        checkOutput({tag, " stallCycles"}, 32'(stall_n), 32'(exp_stall));
        checkOutput({tag, " validCycles"}, 32'(valid_n), 32'(exp_valid));
        checkOutput({tag, " err"}, {31'd0, err}, {31'd0, exp_err});
        checkOutput({tag, " rdata"}, rdata, exp_rdata);
        checkOutput({tag, " doneValid"}, {31'd0, bus_valid}, 32'd0);
    endtask

    task automatic idleCycle(input string tag);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        @(negedge clk);
        checkOutput({tag, " idleStall"}, {31'd0, stall}, 32'd0);
        checkOutput({tag, " idleValid"}, {31'd0, bus_valid}, 32'd0);
        checkOutput({tag, " idleErr"}, {31'd0, err}, 32'd0);
    endtask

    // Safety net in case the clocked sequence never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no end of test expected end before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("reset stall", {31'd0, stall}, 32'd0);
        checkOutput("reset rdata", rdata, 32'd0);
        checkOutput("reset err", {31'd0, err}, 32'd0);
        checkOutput("reset valid", {31'd0, bus_valid}, 32'd0);
        checkOutput("reset we", {31'd0, bus_we}, 32'd0);
        checkOutput("reset addr", bus_addr, 32'd0);
        checkOutput("reset wdata", bus_wdata, 32'd0);
        checkOutput("reset wstrb", {28'd0, bus_wstrb}, 32'd0);
        nextCycle();
        rst = 1'b0;

        // SB to lane 3
        runAccess(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB);
        checkDone("SB", 2, 1, 1'b0, 32'd0);
        checkOutput("SB addr", cap_addr, 32'h0000_1000);
        checkOutput("SB wstrb", cap_wstrb, 32'h8);
        checkOutput("SB wdata", cap_wdata, 32'hABAB_ABAB);
        checkOutput("SB we", cap_we, 32'd1);
        idleCycle("SB");

        // SH to upper half
        runAccess(1'b0, 1'b1, 3'b001, 32'h0000_1002, 32'h0000_BEEF);
        checkDone("SH", 2, 1, 1'b0, 32'd0);
        checkOutput("SH wstrb", cap_wstrb, 32'hC);
        checkOutput("SH wdata", cap_wdata, 32'hBEEF_BEEF);
        idleCycle("SH");

        // LB / LBU lane 1 with three waiting cycles before ready
        ready_delay = 3;
        rvalid_en   = 1'b1;
        resp_word   = 32'h0000_80FF;
        runAccess(1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'd0);
        checkDone("LB", 6, 4, 1'b0, 32'hFFFF_FF80);
        checkOutput("LB addr", cap_addr, 32'h0000_2000);
        checkOutput("LB wstrb", cap_wstrb, 32'h0);
        checkOutput("LB we", cap_we, 32'd0);
        idleCycle("LB");
        runAccess(1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'd0);
        checkDone("LBU", 6, 4, 1'b0, 32'h0000_0080);
        idleCycle("LBU");

        // LW with no read response: 8 cycles in REQ+WAIT, then error
        ready_delay = 0;
        rvalid_en   = 1'b0;
        runAccess(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0);
        checkDone("LWtimeout", 9, 1, 1'b1, 32'd0);
        idleCycle("LWtimeout");

        // Back-to-back SW then LW with no idle gap
        rvalid_en = 1'b1;
        resp_word = 32'hDEAD_BEEF;
        hs_before = hs_count;
        runAccess(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
        checkDone("SW", 2, 1, 1'b0, 32'd0);
        checkOutput("SW wstrb", cap_wstrb, 32'hF);
        checkOutput("SW wdata", cap_wdata, 32'hDEAD_BEEF);
        runAccess(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'd0);
        checkDone("LW", 3, 1, 1'b0, 32'hDEAD_BEEF);
        checkOutput("b2b handshakes", 32'(hs_count - hs_before), 32'd2);
        idleCycle("LW");

        // Reset for two cycles while a request is pending
        ready_delay = 20;
        nextCycle();
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0080, 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("rstmid validBefore", {31'd0, bus_valid}, 32'd1);
        nextCycle();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("rstmid valid", {31'd0, bus_valid}, 32'd0);
        checkOutput("rstmid rdata", rdata, 32'd0);
        checkOutput("rstmid err", {31'd0, err}, 32'd0);
        checkOutput("rstmid addr", bus_addr, 32'd0);
        nextCycle();
        rst = 1'b0;
        ready_delay = 0;
        @(negedge clk);
        checkOutput("rstmid stall", {31'd0, stall}, 32'd0);
        checkOutput("rstmid validAfter", {31'd0, bus_valid}, 32'd0);

        // LH / LHU from upper half
        resp_word = 32'h8001_1234;
        runAccess(1'b1, 1'b0, 3'b001, 32'h0000_3002, 32'd0);
        checkDone("LH", 3, 1, 1'b0, 32'hFFFF_8001);
        idleCycle("LH");
        runAccess(1'b1, 1'b0, 3'b101, 32'h0000_3002, 32'd0);
        checkDone("LHU", 3, 1, 1'b0, 32'h0000_8001);
        idleCycle("LHU");

        // Error paths: no bus traffic, one stall cycle, err pulse
        hs_before = hs_count;
        runAccess(1'b1, 1'b0, 3'b001, 32'h0000_2003, 32'd0);
        checkDone("LHmisalign", 1, 0, 1'b1, 32'd0);
        idleCycle("LHmisalign");
        runAccess(1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'd0);
        checkDone("storeOp100", 1, 0, 1'b1, 32'd0);
        idleCycle("storeOp100");
        runAccess(1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'd0);
        checkDone("rdAndWr", 1, 0, 1'b1, 32'd0);
        idleCycle("rdAndWr");
        checkOutput("error handshakes", 32'(hs_count - hs_before), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
